// File: rtl/regfile_port_arbiter.sv
// Shares the single register-file port between NUM_REQ requesters.
// Build option REGARB_RR_EN: round-robin arbitration (default: fixed priority).
module regfile_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [1:0]                grant_id,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      rf_write,
  input  logic [DATA_W-1:0]         rf_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] win;

`ifdef REGARB_RR_EN
  logic [1:0] last;
  int         idx;
  logic       found;

  // search starts just after the last winner
  always_comb begin
    win   = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (|req) nxt = S_ACCESS;
      S_ACCESS: nxt = S_ACK;
      S_ACK:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      rf_write <= 1'b0;
`ifdef REGARB_RR_EN
      last     <= 2'(NUM_REQ - 1);
`endif
    end else begin
      busy <= (nxt != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            grant_id <= win;
            rf_addr  <= req_addr[win*ADDR_W +: ADDR_W];
            rf_wdata <= req_wdata[win*DATA_W +: DATA_W];
            rf_write <= req_we[win];
`ifdef REGARB_RR_EN
            last     <= win;
`endif
          end
        end
        S_ACCESS: begin
          // write already landed at the negedge, so this is the readback
          rdata         <= rf_rdata;
          ack           <= '0;
          ack[grant_id] <= 1'b1;
          rf_write      <= 1'b0;
          rf_addr       <= '0;
        end
        S_ACK: begin
          ack <= '0;
        end
        default: begin
          ack <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter.
// Covers both REGARB_RR_EN builds.
module tb_regfile_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 3;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [1:0]      grant_id;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_wdata;
  logic            rf_write;
  logic [DW-1:0]   rf_rdata;

  logic [DW-1:0]   rf [8];

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_port_arbiter #(
    .NUM_REQ(N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .grant_id (grant_id),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_write (rf_write),
    .rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  // register file model: x0 reads zero, writes land on negedge
  assign rf_rdata = (rf_addr == 0) ? '0 : rf[rf_addr];

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = DW'(6'h10 + i);
    forever begin
      @(negedge clk);
      if (rf_write && rf_addr != 0) rf[rf_addr] = rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack != 0) begin
        chk("ack_onehot", 32'($onehot(ack)), 1);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=%b required=none", ack);
        end else begin
          e = sbq.pop_front();
          chk("ack_id", 32'(ack), 32'(1) << e.id);
          chk("rdata", 32'(rdata), 32'(e.data));
        end
      end
    end
  endtask

  task automatic set_req(input int id, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[id]               = 1'b1;
    req_we[id]            = we;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
  endtask

  task automatic expect_ack(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic access(input int id, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd);
    @(posedge clk); #1;
    set_req(id, we, a, d);
    expect_ack(id, exp_rd);
    @(posedge clk); #1;
    chk("rf_write_set", 32'(rf_write), 32'(we));
    chk("rf_addr_set", 32'(rf_addr), 32'(a));
    chk("busy_access", 32'(busy), 1);
    chk("grant_id", 32'(grant_id), 32'(id));
    if (we) chk("rf_wdata", 32'(rf_wdata), 32'(d));
    // later field changes must be ignored
    req_addr[id*AW +: AW]  = a ^ 3'b111;
    req_wdata[id*DW +: DW] = ~d;
    @(posedge clk); #1;
    chk("ack_latency", 32'(ack[id]), 1);
    chk("rf_write_clr", 32'(rf_write), 0);
    chk("rf_addr_clr", 32'(rf_addr), 0);
    @(posedge clk); #1;
    req[id] = 1'b0;
    chk("ack_drop", 32'(ack), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rf_write", 32'(rf_write), 0);
    chk("rst_rf_addr", 32'(rf_addr), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_rdata", 32'(rdata), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ack", 32'(ack), 0);

    access(2, 1'b1, 3'd5, 6'h2A, 6'h2A);
    access(0, 1'b0, 3'd5, 6'h00, 6'h2A);
    access(1, 1'b1, 3'd0, 6'h3F, 6'h00);
    access(1, 1'b0, 3'd0, 6'h00, 6'h00);

    // contention with requests held from a fresh pointer
    do_reset();
    @(posedge clk); #1;
    req_we = '0;
`ifdef REGARB_RR_EN
    set_req(0, 1'b0, 3'd1, 6'h00);
    set_req(1, 1'b0, 3'd2, 6'h00);
    set_req(2, 1'b0, 3'd3, 6'h00);
    expect_ack(0, 6'h11);
    expect_ack(1, 6'h12);
    expect_ack(2, 6'h13);
    expect_ack(0, 6'h11);
`else
    set_req(0, 1'b0, 3'd1, 6'h00);
    set_req(1, 1'b0, 3'd2, 6'h00);
    expect_ack(0, 6'h11);
    expect_ack(0, 6'h11);
    expect_ack(0, 6'h11);
    expect_ack(0, 6'h11);
`endif
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (ack != 0) n++;
    end
    req = '0;
    chk("contention_acks", 32'(n), 4);
    repeat (2) @(posedge clk);
    #1;

    // reset lands while a read is in ACCESS
    set_req(1, 1'b0, 3'd3, 6'h00);
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    req   = '0;
    reset = 1'b1;
    chk("mid_ack", 32'(ack), 0);
    chk("mid_busy_clr", 32'(busy), 0);
    chk("mid_rf_write", 32'(rf_write), 0);
    chk("mid_rdata", 32'(rdata), 0);
    chk("mid_grant_id", 32'(grant_id), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_ack", 32'(ack), 0);

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
